instr_fetch: RTL and testbench



---
 rtl/instr_fetch_if.sv | 31 +++
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//
// Signals:
//   imem_req   - fetch request, driven by the fetch stage
//   imem_addr  - word-aligned fetch address, driven by the fetch stage
//   imem_ack   - memory returns imem_rdata this cycle
//   imem_rdata - instruction word, valid while imem_ack is high
//
// Modports:
//   master - fetch stage side
//   slave  - instruction memory side
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage of the MIPS core.
//
// Holds the program counter and fetches one instruction per step over a
// variable-latency memory handshake. The fetched word is held for decode and
// execute behind a valid/ready pair. When the instruction retires, the next PC
// is chosen from the decoder's Jump/Branch outputs and the ALU Zero flag.
//
// Parameters:
//   RESET_PC    - PC loaded on reset; bits [1:0] are forced to zero
//
// Ports:
//   clk         - sole clock, rising edge
//   reset       - synchronous, active-high reset
//   imem        - instruction-memory bus (master side)
//   instr       - held instruction word; instr[31:26] feeds the decoder
//   instr_valid - instr is valid for decode/execute
//   instr_ready - execute has completed instr; retire it
//   Branch      - branch indication from the decoder
//   Jump        - jump indication from the decoder
//   Zero        - zero flag from the ALU
//   pc          - address of the current or fetching instruction
//   pc_plus4    - pc + 4, combinational
//   retired     - count of retired instructions, wraps at 2^32
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 reset,
   instr_fetch_if.master        imem,
   output logic [31:0]          instr,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   input  logic                 Branch,
   input  logic                 Jump,
   input  logic                 Zero,
   output logic [31:0]          pc,
   output logic [31:0]          pc_plus4,
   output logic [31:0]          retired
);

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_t      state;
   state_t      state_next;
   logic [31:0] pc_next;
   logic [31:0] instr_next;
   logic [31:0] retired_next;
   logic [31:0] pc_target;
   logic [31:0] branch_offset;

   // State register. Reset on any state abandons an outstanding fetch: the
   // FSM restarts in FETCH at the reset PC, so an ack seen afterwards is
   // taken as the fetch of that address.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         pc      <= RESET_PC_ALIGNED;
         instr   <= 32'h0000_0000;
         retired <= 32'h0000_0000;
      end else begin
         state   <= state_next;
         pc      <= pc_next;
         instr   <= instr_next;
         retired <= retired_next;
      end
   end

   assign pc_plus4       = pc + 32'd4;
   assign imem.imem_addr = pc;

   // Sign-extended word offset of a conditional branch.
   assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

   // Next-PC selection. Jump outranks a taken branch; every candidate is
   // word aligned because pc and both offsets have zero low bits.
   always_comb begin
      pc_target = pc_plus4;
      if (Jump) begin
         pc_target = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (Branch && Zero) begin
         pc_target = pc_plus4 + branch_offset;
      end
   end

   // Next-state and output logic. The request is masked while reset is high
   // so memory never sees a fetch that is about to be abandoned.
   always_comb begin
      state_next    = state;
      pc_next       = pc;
      instr_next    = instr;
      retired_next  = retired;
      imem.imem_req = 1'b0;
      instr_valid   = 1'b0;
      case (state)
         FETCH: begin
            imem.imem_req = ~reset;
            if (imem.imem_ack) begin
               instr_next = imem.imem_rdata;
               state_next = HOLD;
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            if (instr_ready) begin
               pc_next      = pc_target;
               retired_next = retired + 32'd1;
               state_next   = FETCH;
            end
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch.
//
// Four copies of the fetch stage with different reset PCs share one set of
// memory and decoder inputs. Their state machines depend only on those shared
// inputs, so they move in lockstep while their PCs exercise different address
// regions (reset alignment, 256 MB region crossing on jump, 32-bit wrap).
// Instruction words are pushed to a queue when the memory acks and popped when
// the stage presents them.
module tb_instr_fetch;

   localparam logic [31:0] R_INSTR   = 32'h012A_4020;
   localparam logic [31:0] J_INSTR   = 32'h0800_0040;
   localparam logic [31:0] BEQ_INSTR = 32'h1000_FFFE;
   localparam logic [31:0] STALE     = 32'hBAD0_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ack = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic        ready = 1'b0;
   logic        br = 1'b0;
   logic        jmp = 1'b0;
   logic        zr = 1'b0;

   logic [31:0] instr_o [4];
   logic        valid_o [4];
   logic [31:0] pc_o    [4];
   logic [31:0] pc4_o   [4];
   logic [31:0] ret_o   [4];

   int          n_assert = 0;
   int          n_fail = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   instr_fetch_if if_a ();
   instr_fetch_if if_b ();
   instr_fetch_if if_c ();
   instr_fetch_if if_d ();

   assign if_a.imem_ack   = ack;
   assign if_a.imem_rdata = rdata;
   assign if_b.imem_ack   = ack;
   assign if_b.imem_rdata = rdata;
   assign if_c.imem_ack   = ack;
   assign if_c.imem_rdata = rdata;
   assign if_d.imem_ack   = ack;
   assign if_d.imem_rdata = rdata;

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut_a (
      .clk(clk), .reset(reset), .imem(if_a),
      .instr(instr_o[0]), .instr_valid(valid_o[0]), .instr_ready(ready),
      .Branch(br), .Jump(jmp), .Zero(zr),
      .pc(pc_o[0]), .pc_plus4(pc4_o[0]), .retired(ret_o[0])
   );

   instr_fetch #(.RESET_PC(32'h0040_0003)) dut_b (
      .clk(clk), .reset(reset), .imem(if_b),
      .instr(instr_o[1]), .instr_valid(valid_o[1]), .instr_ready(ready),
      .Branch(br), .Jump(jmp), .Zero(zr),
      .pc(pc_o[1]), .pc_plus4(pc4_o[1]), .retired(ret_o[1])
   );

   instr_fetch #(.RESET_PC(32'h0FFF_FFFC)) dut_c (
      .clk(clk), .reset(reset), .imem(if_c),
      .instr(instr_o[2]), .instr_valid(valid_o[2]), .instr_ready(ready),
      .Branch(br), .Jump(jmp), .Zero(zr),
      .pc(pc_o[2]), .pc_plus4(pc4_o[2]), .retired(ret_o[2])
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_d (
      .clk(clk), .reset(reset), .imem(if_d),
      .instr(instr_o[3]), .instr_valid(valid_o[3]), .instr_ready(ready),
      .Branch(br), .Jump(jmp), .Zero(zr),
      .pc(pc_o[3]), .pc_plus4(pc4_o[3]), .retired(ret_o[3])
   );

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic check_output(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Fetch one word at exp_addr after `waits` cycles without ack.
   task automatic fetch_instr(input int waits, input logic [31:0] data,
                              input logic [31:0] exp_addr);
      logic [31:0] exp_instr;
      for (int i = 0; i < waits; i++) begin
         rdata = STALE;
         check_output("wait_req", {31'b0, if_a.imem_req}, 32'd1);
         check_output("wait_addr", if_a.imem_addr, exp_addr);
         check_output("wait_valid", {31'b0, valid_o[0]}, 32'd0);
         step();
      end
      check_output("fetch_req", {31'b0, if_a.imem_req}, 32'd1);
      check_output("fetch_addr", if_a.imem_addr, exp_addr);
      ack   = 1'b1;
      rdata = data;
      exp_q.push_back(data);
      step();
      ack   = 1'b0;
      rdata = STALE;
      check_output("hold_valid", {31'b0, valid_o[0]}, 32'd1);
      check_output("hold_req", {31'b0, if_a.imem_req}, 32'd0);
      if (exp_q.size() == 0) begin
         check_output("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         exp_instr = exp_q.pop_front();
         check_output("instr", instr_o[0], exp_instr);
      end
   endtask

   // Retire the held instruction with the given decoder/ALU inputs.
   task automatic retire_instr(input logic j, input logic b, input logic z,
                               input logic [31:0] exp_retired);
      jmp   = j;
      br    = b;
      zr    = z;
      ready = 1'b1;
      step();
      ready = 1'b0;
      jmp   = 1'b0;
      br    = 1'b0;
      zr    = 1'b0;
      check_output("retire_valid", {31'b0, valid_o[0]}, 32'd0);
      check_output("retire_req", {31'b0, if_a.imem_req}, 32'd1);
      check_output("retired", ret_o[0], exp_retired);
   endtask

   initial begin
      // Reset held for two cycles.
      reset = 1'b1;
      step();
      check_output("rst_req_low", {31'b0, if_b.imem_req}, 32'd0);
      step();
      check_output("rst_pc_b", pc_o[1], 32'h0040_0000);
      check_output("rst_valid_b", {31'b0, valid_o[1]}, 32'd0);
      check_output("rst_retired_b", ret_o[1], 32'd0);
      check_output("rst_instr_b", instr_o[1], 32'd0);
      check_output("rst_pc_a", pc_o[0], 32'h0000_0000);
      check_output("rst_pc_c", pc_o[2], 32'h0FFF_FFFC);
      check_output("rst_pc_d", pc_o[3], 32'hFFFF_FFFC);
      reset = 1'b0;
      #1;
      check_output("rel_req_b", {31'b0, if_b.imem_req}, 32'd1);
      check_output("rel_addr_b", if_b.imem_addr, 32'h0040_0000);

      // Sequential retire: wrap on D, region crossing on C.
      fetch_instr(0, R_INSTR, 32'h0000_0000);
      check_output("pc4_d", pc4_o[3], 32'h0000_0000);
      retire_instr(1'b0, 1'b0, 1'b0, 32'd1);
      check_output("wrap_pc_d", pc_o[3], 32'h0000_0000);
      check_output("seq_pc_c", pc_o[2], 32'h1000_0000);
      check_output("seq_pc_a", pc_o[0], 32'h0000_0004);

      // Jump with Branch and Zero also high.
      fetch_instr(0, J_INSTR, 32'h0000_0004);
      retire_instr(1'b1, 1'b1, 1'b1, 32'd2);
      check_output("jump_pc_c", pc_o[2], 32'h1000_0100);
      check_output("jump_pc_a", pc_o[0], 32'h0000_0100);
      check_output("jump_pc_d", pc_o[3], 32'h0000_0100);

      // Taken backward branch from 0x100.
      fetch_instr(0, BEQ_INSTR, 32'h0000_0100);
      retire_instr(1'b0, 1'b1, 1'b1, 32'd3);
      check_output("br_taken_pc", pc_o[0], 32'h0000_00FC);

      // Back to 0x100, then branch not taken, holding in HOLD first.
      fetch_instr(0, J_INSTR, 32'h0000_00FC);
      retire_instr(1'b1, 1'b0, 1'b0, 32'd4);
      check_output("jump_back_pc", pc_o[0], 32'h0000_0100);
      fetch_instr(0, BEQ_INSTR, 32'h0000_0100);
      for (int i = 0; i < 2; i++) begin
         step();
         check_output("stall_valid", {31'b0, valid_o[0]}, 32'd1);
         check_output("stall_pc", pc_o[0], 32'h0000_0100);
         check_output("stall_instr", instr_o[0], BEQ_INSTR);
         check_output("stall_retired", ret_o[0], 32'd4);
      end
      check_output("stall_pc4", pc4_o[0], 32'h0000_0104);
      retire_instr(1'b0, 1'b1, 1'b0, 32'd5);
      check_output("br_not_taken_pc", pc_o[0], 32'h0000_0104);

      // Three wait states; ready high in FETCH must be ignored.
      ready = 1'b1;
      fetch_instr(3, R_INSTR, 32'h0000_0104);
      retire_instr(1'b0, 1'b0, 1'b0, 32'd6);
      check_output("wait_next_pc", pc_o[0], 32'h0000_0108);

      // Reset in HOLD while retiring a jump.
      fetch_instr(0, J_INSTR, 32'h0000_0108);
      reset = 1'b1;
      ready = 1'b1;
      jmp   = 1'b1;
      step();
      check_output("mid_rst_pc", pc_o[0], 32'h0000_0000);
      check_output("mid_rst_pc_b", pc_o[1], 32'h0040_0000);
      check_output("mid_rst_retired", ret_o[0], 32'd0);
      check_output("mid_rst_valid", {31'b0, valid_o[0]}, 32'd0);
      check_output("mid_rst_instr", instr_o[0], 32'd0);
      check_output("mid_rst_req", {31'b0, if_a.imem_req}, 32'd0);
      reset = 1'b0;
      ready = 1'b0;
      jmp   = 1'b0;
      #1;
      check_output("mid_rel_req", {31'b0, if_a.imem_req}, 32'd1);
      check_output("mid_rel_addr", if_a.imem_addr, 32'h0000_0000);

      // Four sequential R-type instructions, zero-wait, ready tied high.
      for (int i = 0; i < 4; i++) begin
         ready = 1'b1;
         fetch_instr(0, R_INSTR + 32'(i), 32'(4 * i));
         retire_instr(1'b0, 1'b0, 1'b0, 32'(i + 1));
      end
      check_output("seq_final_pc", pc_o[0], 32'h0000_0010);
      check_output("seq_final_retired", ret_o[0], 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
